exec_cc_reg: RTL

EXEC_CC_REG -- requirements
Module: exec_cc_reg

---
 rtl/exec_cc_reg.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/exec_cc_reg.sv
// Execute-stage condition-code register, branch/cmov condition evaluation and
// the execute-to-memory pipeline register. Optional taken-counter: EXEC_PERF_CNT_EN.
module exec_cc_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_valid,
    input  logic [3:0]  e_icode,
    input  logic [3:0]  e_ifun,
    input  logic [1:0]  alu_fun,
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic        set_cc,
    input  logic        w_exception,
    input  logic        m_stall,
    input  logic        m_bubble,
    output logic        cc_zf,
    output logic        cc_sf,
    output logic        cc_of,
    output logic        e_cnd,
    output logic        M_valid,
    output logic        M_cnd,
    output logic [3:0]  M_icode,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0] perf_taken
`endif
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned IW     = 4;
    localparam int unsigned MSB    = XLEN - 1;
    localparam logic [IW-1:0] REG_NONE   = IW'(4'hF);
    localparam logic [IW-1:0] ICODE_NOP  = IW'(4'h1);
    localparam logic [IW-1:0] ICODE_CMOV = IW'(4'h2);
    localparam logic [IW-1:0] ICODE_JXX  = IW'(4'h7);
    localparam logic [1:0]    ALU_ADD    = 2'(0);
    localparam logic [1:0]    ALU_SUB    = 2'(1);

    // Only the sign bits of the operands matter for overflow detection.
    logic unused_alu_low_c;
    assign unused_alu_low_c = ^{alu_a[MSB-1:0], alu_b[MSB-1:0]};

    logic flag_zf_c;
    logic flag_sf_c;
    logic flag_of_c;
    logic cc_load_c;

    logic cc_zf_q, cc_zf_d;
    logic cc_sf_q, cc_sf_d;
    logic cc_of_q, cc_of_d;

    logic            m_valid_q, m_valid_d;
    logic            m_cnd_q,   m_cnd_d;
    logic [IW-1:0]   m_icode_q, m_icode_d;
    logic [XLEN-1:0] m_vale_q,  m_vale_d;
    logic [XLEN-1:0] m_vala_q,  m_vala_d;
    logic [IW-1:0]   m_dste_q,  m_dste_d;
    logic [IW-1:0]   m_dstm_q,  m_dstm_d;

    // Flags derived from the ALU result already computed upstream.
    always_comb begin
        flag_zf_c = (e_valE == '0);
        flag_sf_c = e_valE[MSB];
        flag_of_c = 1'b0;
        case (alu_fun)
            ALU_ADD: flag_of_c = (alu_a[MSB] == alu_b[MSB]) && (e_valE[MSB] != alu_a[MSB]);
            ALU_SUB: flag_of_c = (alu_a[MSB] != alu_b[MSB]) && (e_valE[MSB] != alu_b[MSB]);
            default: flag_of_c = 1'b0;
        endcase
    end

    assign cc_load_c = set_cc && e_valid && !w_exception && !m_stall;

    always_comb begin
        cc_zf_d = cc_zf_q;
        cc_sf_d = cc_sf_q;
        cc_of_d = cc_of_q;
        if (cc_load_c) begin
            cc_zf_d = flag_zf_c;
            cc_sf_d = flag_sf_c;
            cc_of_d = flag_of_c;
        end
    end

    // Condition uses only the registered flags, giving one cycle of OPq->jXX latency.
    always_comb begin
        e_cnd = 1'b0;
        case (e_ifun)
            4'd0:    e_cnd = 1'b1;
            4'd1:    e_cnd = (cc_sf_q ^ cc_of_q) | cc_zf_q;
            4'd2:    e_cnd = cc_sf_q ^ cc_of_q;
            4'd3:    e_cnd = cc_zf_q;
            4'd4:    e_cnd = !cc_zf_q;
            4'd5:    e_cnd = !(cc_sf_q ^ cc_of_q);
            4'd6:    e_cnd = !(cc_sf_q ^ cc_of_q) && !cc_zf_q;
            default: e_cnd = 1'b0;
        endcase
    end

    // Pipeline register: bubble beats stall, stall holds, otherwise load.
    always_comb begin
        m_valid_d = m_valid_q;
        m_cnd_d   = m_cnd_q;
        m_icode_d = m_icode_q;
        m_vale_d  = m_vale_q;
        m_vala_d  = m_vala_q;
        m_dste_d  = m_dste_q;
        m_dstm_d  = m_dstm_q;
        if (m_bubble) begin
            m_valid_d = 1'b0;
            m_cnd_d   = 1'b0;
            m_icode_d = ICODE_NOP;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = REG_NONE;
            m_dstm_d  = REG_NONE;
        end else if (!m_stall) begin
            m_valid_d = e_valid;
            m_cnd_d   = e_cnd;
            m_icode_d = e_icode;
            m_vale_d  = e_valE;
            m_vala_d  = e_valA;
            m_dste_d  = (e_icode == ICODE_CMOV && !e_cnd) ? REG_NONE : e_dstE;
            m_dstm_d  = e_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_zf_q   <= 1'b1;
            cc_sf_q   <= 1'b0;
            cc_of_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_cnd_q   <= 1'b0;
            m_icode_q <= ICODE_NOP;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= REG_NONE;
            m_dstm_q  <= REG_NONE;
        end else begin
            cc_zf_q   <= cc_zf_d;
            cc_sf_q   <= cc_sf_d;
            cc_of_q   <= cc_of_d;
            m_valid_q <= m_valid_d;
            m_cnd_q   <= m_cnd_d;
            m_icode_q <= m_icode_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign cc_zf   = cc_zf_q;
    assign cc_sf   = cc_sf_q;
    assign cc_of   = cc_of_q;
    assign M_valid = m_valid_q;
    assign M_cnd   = m_cnd_q;
    assign M_icode = m_icode_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

`ifdef EXEC_PERF_CNT_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] perf_taken_q, perf_taken_d;

    // Counts taken cmov/jXX entering memory; wraps naturally at all-ones.
    always_comb begin
        perf_taken_d = perf_taken_q;
        if (!m_bubble && !m_stall && e_valid && e_cnd &&
            (e_icode == ICODE_CMOV || e_icode == ICODE_JXX)) begin
            perf_taken_d = perf_taken_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_taken_q <= '0;
        end else begin
            perf_taken_q <= perf_taken_d;
        end
    end

    assign perf_taken = perf_taken_q;
`endif

endmodule
